// File: rtl/down_counter_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_timer_if
// Description : Control/status bundle for the loadable down-counter/timer.
//               The controller side drives the commands, the timer answers
//               with its count and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface down_counter_timer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [7:0]       done_cnt;

  // Controller side: issues commands, observes status
  modport master (
    output load, load_val, start, pause, auto_reload,
    input  count, busy, done, done_cnt
  );

  // Timer side: accepts commands, reports status
  modport slave (
    input  load, load_val, start, pause, auto_reload,
    output count, busy, done, done_cnt
  );
endinterface
`default_nettype wire

// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_timer
// Description : Loadable down-counter/timer. Counts a programmed value down
//               to zero and emits a one-cycle done pulse, optionally
//               reloading for periodic ticks. Control priority per edge is
//               load > start > pause.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter_timer #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  down_counter_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;
  logic [7:0]       r_done_cnt;

  // Timer state machine: load aborts everything, otherwise per-state control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_count    <= c_zero;
      r_reload   <= c_zero;
      r_done     <= 1'b0;
      r_done_cnt <= 8'd0;
    end else begin
      // done is a strobe: only the terminal-count branches raise it
      r_done <= 1'b0;
      if (bus.load) begin
        r_reload   <= bus.load_val;
        r_count    <= bus.load_val;
        r_done_cnt <= 8'd0;
        r_state    <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              if (r_count != c_zero) begin
                r_state <= ST_RUN;
              end else begin
                // Zero-length run terminates immediately
                r_state    <= ST_DONE;
                r_done     <= 1'b1;
                r_done_cnt <= r_done_cnt + 8'd1;
              end
            end
          end
          ST_RUN: begin
            if (bus.pause) begin
              r_state <= ST_HOLD;
            end else if (r_count > c_one) begin
              r_count <= r_count - c_one;
            end else begin
              // Terminal count; auto_reload matters only here
              r_done     <= 1'b1;
              r_done_cnt <= r_done_cnt + 8'd1;
              if (bus.auto_reload && (r_reload != c_zero)) begin
                // Skip the zero value so the period equals the reload value
                r_count <= r_reload;
              end else begin
                r_count <= c_zero;
                r_state <= ST_DONE;
              end
            end
          end
          ST_HOLD: begin
            // Leaving HOLD costs one edge; decrementing resumes after it
            if (!bus.pause) begin
              r_state <= ST_RUN;
            end
          end
          ST_DONE: begin
            if (bus.start) begin
              if (r_reload != c_zero) begin
                r_count <= r_reload;
                r_state <= ST_RUN;
              end else begin
                r_count    <= c_zero;
                r_done     <= 1'b1;
                r_done_cnt <= r_done_cnt + 8'd1;
              end
            end else begin
              r_count <= c_zero;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.busy     = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign bus.done     = r_done;
  assign bus.done_cnt = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_counter_timer
// Description : Directed self-checking bench for down_counter_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_timer;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  down_counter_timer_if #(.WIDTH(8)) bus ();

  down_counter_timer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load        = 1'b0;
    bus.load_val    = 8'd0;
    bus.start       = 1'b0;
    bus.pause       = 1'b0;
    bus.auto_reload = 1'b0;
  endtask

  task automatic test_reset();
    n_total++; if (bus.count !== 8'd0) $display("FAIL rst_count got=%h exp=00", bus.count); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL rst_done got=%b exp=0", bus.done); else n_pass++;
    n_total++; if (bus.done_cnt !== 8'd0) $display("FAIL rst_done_cnt got=%0d exp=0", bus.done_cnt); else n_pass++;

    // Build up pulses, then reset asynchronously while done is high
    bus.load = 1'b1; bus.load_val = 8'd0; tick(); bus.load = 1'b0;
    bus.start = 1'b1; tick(); tick(); bus.start = 1'b0;
    n_total++; if (bus.done_cnt !== 8'd2) $display("FAIL pre_rst_done_cnt got=%0d exp=2", bus.done_cnt); else n_pass++;
    #2; rst = 1'b1; #1;
    n_total++; if (bus.done !== 1'b0) $display("FAIL async_rst_done got=%b exp=0", bus.done); else n_pass++;
    n_total++; if (bus.done_cnt !== 8'd0) $display("FAIL async_rst_done_cnt got=%0d exp=0", bus.done_cnt); else n_pass++;
    tick(); rst = 1'b0;

    // Mid-run async reset with count = 0x23
    bus.load = 1'b1; bus.load_val = 8'h23; tick(); bus.load = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL run_busy got=%b exp=1", bus.busy); else n_pass++;
    n_total++; if (bus.count !== 8'h23) $display("FAIL run_count got=%h exp=23", bus.count); else n_pass++;
    #2; rst = 1'b1; #1;
    n_total++; if (bus.count !== 8'd0) $display("FAIL mid_rst_count got=%h exp=00", bus.count); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.done !== 1'b0) $display("FAIL mid_rst_done got=%b exp=0", bus.done); else n_pass++;
    tick(); rst = 1'b0;

    // Reload register was cleared: back-to-back starts pulse done with count 0
    bus.start = 1'b1; tick();
    n_total++; if (bus.done !== 1'b1) $display("FAIL post_rst_start1_done got=%b exp=1", bus.done); else n_pass++;
    tick(); bus.start = 1'b0;
    n_total++; if (bus.done !== 1'b1) $display("FAIL post_rst_start2_done got=%b exp=1", bus.done); else n_pass++;
    n_total++; if (bus.count !== 8'd0) $display("FAIL post_rst_reload_count got=%h exp=00", bus.count); else n_pass++;
    n_total++; if (bus.done_cnt !== 8'd2) $display("FAIL post_rst_done_cnt got=%0d exp=2", bus.done_cnt); else n_pass++;
  endtask

  task automatic test_one_shot();
    bus.load = 1'b1; bus.load_val = 8'd5; tick(); bus.load = 1'b0;
    n_total++; if (bus.count !== 8'd5) $display("FAIL os_load_count got=%0d exp=5", bus.count); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL os_load_busy got=%b exp=0", bus.busy); else n_pass++;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_total++; if (bus.count !== 8'd5) $display("FAIL os_edge0_count got=%0d exp=5", bus.count); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL os_edge0_busy got=%b exp=1", bus.busy); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_total++; if (bus.count !== 8'(5 - k)) $display("FAIL os_count edge=%0d got=%0d exp=%0d", k, bus.count, 5 - k); else n_pass++;
      n_total++; if (bus.done !== (k == 5)) $display("FAIL os_done edge=%0d got=%b exp=%b", k, bus.done, (k == 5)); else n_pass++;
      n_total++; if (bus.busy !== (k != 5)) $display("FAIL os_busy edge=%0d got=%b exp=%b", k, bus.busy, (k != 5)); else n_pass++;
    end
    tick();
    n_total++; if (bus.done !== 1'b0) $display("FAIL os_done_after got=%b exp=0", bus.done); else n_pass++;
    n_total++; if (bus.count !== 8'd0) $display("FAIL os_count_after got=%0d exp=0", bus.count); else n_pass++;
    n_total++; if (bus.done_cnt !== 8'd1) $display("FAIL os_done_cnt got=%0d exp=1", bus.done_cnt); else n_pass++;
  endtask

  task automatic test_pause();
    // Pause sampled at edges 2 and 3, resume edge 4: count holds at 3 over edges 2..4
    logic [7:0] exp_cnt [1:7];
    exp_cnt = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
    bus.load = 1'b1; bus.load_val = 8'd4; tick(); bus.load = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      bus.pause = (k == 2) || (k == 3);
      tick();
      n_total++; if (bus.count !== exp_cnt[k]) $display("FAIL pause_count edge=%0d got=%0d exp=%0d", k, bus.count, exp_cnt[k]); else n_pass++;
      n_total++; if (bus.done !== (k == 7)) $display("FAIL pause_done edge=%0d got=%b exp=%b", k, bus.done, (k == 7)); else n_pass++;
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_c;
    int         pulses;
    int         m;
    pulses = 0;
    bus.auto_reload = 1'b1;
    bus.load = 1'b1; bus.load_val = 8'd3; tick(); bus.load = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 1; k <= 768; k++) begin
      tick();
      m = k % 3;
      exp_c = (m == 0) ? 8'd3 : 8'(3 - m);
      if (bus.done === 1'b1) pulses++;
      n_total++; if (bus.count !== exp_c) $display("FAIL ar_count edge=%0d got=%0d exp=%0d", k, bus.count, exp_c); else n_pass++;
      n_total++; if (bus.done !== (m == 0)) $display("FAIL ar_done edge=%0d got=%b exp=%b", k, bus.done, (m == 0)); else n_pass++;
    end
    n_total++; if (pulses != 256) $display("FAIL ar_pulses got=%0d exp=256", pulses); else n_pass++;
    n_total++; if (bus.done_cnt !== 8'd0) $display("FAIL ar_done_cnt_wrap got=%0d exp=0", bus.done_cnt); else n_pass++;
    n_total++; if (bus.busy !== 1'b1) $display("FAIL ar_busy got=%b exp=1", bus.busy); else n_pass++;
    bus.auto_reload = 1'b0;
  endtask

  task automatic test_priority();
    bus.load = 1'b1; bus.load_val = 8'd0; tick(); bus.load = 1'b0;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL pri_load_abort_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.done_cnt !== 8'd0) $display("FAIL pri_load_done_cnt got=%0d exp=0", bus.done_cnt); else n_pass++;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    n_total++; if (bus.done !== 1'b1) $display("FAIL pri_zero_done got=%b exp=1", bus.done); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL pri_zero_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.done_cnt !== 8'd1) $display("FAIL pri_zero_done_cnt got=%0d exp=1", bus.done_cnt); else n_pass++;
    tick();
    n_total++; if (bus.done !== 1'b0) $display("FAIL pri_zero_done_once got=%b exp=0", bus.done); else n_pass++;
    // load and start together: only load acts
    bus.load = 1'b1; bus.start = 1'b1; bus.load_val = 8'd6; tick();
    bus.load = 1'b0; bus.start = 1'b0;
    n_total++; if (bus.count !== 8'd6) $display("FAIL pri_ls_count got=%0d exp=6", bus.count); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL pri_ls_busy got=%b exp=0", bus.busy); else n_pass++;
    n_total++; if (bus.done_cnt !== 8'd0) $display("FAIL pri_ls_done_cnt got=%0d exp=0", bus.done_cnt); else n_pass++;
    tick();
    n_total++; if (bus.count !== 8'd6) $display("FAIL pri_ls_idle_count got=%0d exp=6", bus.count); else n_pass++;
  endtask

  task automatic test_restart();
    bus.load = 1'b1; bus.load_val = 8'd7; tick(); bus.load = 1'b0;
    for (int run = 1; run <= 2; run++) begin
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      n_total++; if (bus.count !== 8'd7) $display("FAIL rs_start_count run=%0d got=%0d exp=7", run, bus.count); else n_pass++;
      n_total++; if (bus.busy !== 1'b1) $display("FAIL rs_start_busy run=%0d got=%b exp=1", run, bus.busy); else n_pass++;
      for (int k = 1; k <= 7; k++) begin
        tick();
        n_total++; if (bus.count !== 8'(7 - k)) $display("FAIL rs_count run=%0d edge=%0d got=%0d exp=%0d", run, k, bus.count, 7 - k); else n_pass++;
        n_total++; if (bus.done !== (k == 7)) $display("FAIL rs_done run=%0d edge=%0d got=%b exp=%b", run, k, bus.done, (k == 7)); else n_pass++;
      end
      n_total++; if (bus.done_cnt !== 8'(run)) $display("FAIL rs_done_cnt run=%0d got=%0d exp=%0d", run, bus.done_cnt, run); else n_pass++;
      tick();
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_one_shot();
    test_pause();
    test_auto_reload();
    test_priority();
    test_restart();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
